multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Multi-cycle MIPS-subset control FSM: one instruction over 3-5 states, one shared memory port, one shared ALU.
//  Sits beside datapath regs IR/MDR/A/B/ALUOut; drives all datapath muxes/strobes from current state.
//  Adds memory-ready handshake, wait timeout, illegal-opcode trap and a retired-instruction counter.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter
//  MEM_TIMEOUT  16  max cycles waiting on mem_ready before abort; 0 = wait forever
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  op          in   6      IR[31:26], valid from DECODE onward
//  zero        in   1      ALU zero flag (consumed by datapath via pc_write_cond; monitor only)
//  mem_ready   in   1      memory completes current access this cycle
//  mem_req     out  1      memory access active (FETCH, MEM_READ, MEM_WRITE)
//  mem_read / mem_write / iord / ir_write / mem_to_reg / reg_write / reg_dst / alu_src_a   out 1  datapath strobes/selects
//  pc_write / pc_write_cond / branch_ne                                                    out 1  PC update controls
//  pc_source   out  2      00 ALU, 01 ALUOut, 10 jump target
//  alu_src_b   out  2      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op      out  2      00 add, 01 sub, 10 funct-decoded
//  instr_done  out  1      1-cycle pulse on instruction retire
//  retired     out  CNT_W  retired count, wraps to 0
//  illegal     out  1      1-cycle pulse in TRAP
//  mem_err     out  1      1-cycle pulse on memory timeout abort
// BEHAVIOUR
//  Reset: state=FETCH, retired=0, wait counter=0. While rst_n low, all outputs 0.
//  All control outputs are combinational from state (+mem_ready where noted); no output registers.
//  FETCH: mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//   ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by op:
//   LW 100011/SW 101011 -> MEM_ADDR; R 000000 -> EXECUTE; BEQ 000100 -> BRANCH; J 000010 -> JUMP; else TRAP.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ (LW) / MEM_WRITE (SW).
//  MEM_READ: mem_req, mem_read, iord=1; hold until mem_ready -> MEM_WB.
//  MEM_WB: reg_write, mem_to_reg=1, reg_dst=0; retire -> FETCH.
//  MEM_WRITE: mem_req, mem_write, iord=1; hold until mem_ready; retire -> FETCH.
//  EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB (reg_write, reg_dst=1, mem_to_reg=0; retire -> FETCH).
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01; retire -> FETCH.
//  JUMP: pc_write, pc_source=10; retire -> FETCH.
//  TRAP: illegal=1, no writes, no retire -> FETCH.
//  Retire: instr_done=1 and retired+1 (mod 2^CNT_W) in that cycle; MEM_WRITE retires only on mem_ready.
//  Timeout (MEM_TIMEOUT>0): wait counter clears on entering each mem state, counts cycles with mem_req && !mem_ready;
//   at count==MEM_TIMEOUT-1 with mem_ready still low: mem_err=1, all strobes 0 that cycle, -> FETCH, no retire.
//   mem_ready on the final allowed cycle wins (normal completion).
//  Reset mid-instruction: immediate abort to FETCH, no partial retire, counter cleared.
// CONFIGURATION
//  MC_CTRL_EXT_OPS_EN defined: ADDI 001000 -> ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00)
//   -> ADDI_WB (reg_write, reg_dst=0, mem_to_reg=0; retire); BNE 000101 -> BRANCH with branch_ne=1.
//  Undefined: ADDI/BNE decode to TRAP; ADDI states absent; branch_ne tied 0.
// STRUCTURE
//  Package mc_ctrl_pkg: state enum, opcode constants, ALUOp/PCSource/ALUSrcB encodings.
//  Sub-module mc_ctrl_outdec: combinational state(+mem_ready, timeout) -> control-word decoder.
//  Top holds state register, next-state logic, wait counter, retired counter.
// TESTING
//  R-type, mem_ready tied 1: FETCH,DECODE,EXECUTE,R_WB; instr_done on cycle 4, retired=1, reg_dst=1 in R_WB.
//  LW with mem_ready low 3 cycles in MEM_READ: state holds, mem_req=1, iord=1; MEM_WB follows, 1 retire.
//  SW, mem_ready never high, MEM_TIMEOUT=16: mem_err pulse after 16 wait cycles, back to FETCH, retired unchanged.
//  op=111111: DECODE->TRAP, illegal pulse, no reg_write/mem_write, then FETCH.
//  CNT_W=4, 16 J instructions: retired wraps 15->0; pc_write, pc_source=10 each JUMP.
//  rst_n low in MEM_READ: outputs 0 same cycle; release -> FETCH, retired=0. With MC_CTRL_EXT_OPS_EN, BNE: branch_ne=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
// Holds the FSM state enum, opcode constants and the ALUOp / PCSource /
// ALUSrcB encodings used by both the top and the output decoder.
// Optional feature macro: MC_CTRL_EXT_OPS_EN (adds ADDI states and BNE opcode).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd10
`ifdef MC_CTRL_EXT_OPS_EN
    ,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12
`endif
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_EXT_OPS_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that own the shared memory port
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Control-word decoder for the multi-cycle controller.
// Purely combinational: maps the current state (plus mem_ready and the
// memory-timeout flag) onto every datapath strobe/select.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory completes the current access this cycle
//   timeout_i    memory wait expired this cycle (forces all strobes low)
//   *_o          datapath controls, instr_done/illegal/mem_err status pulses
// Optional feature macro: MC_CTRL_EXT_OPS_EN (decodes ADDI_EX / ADDI_WB).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic        mem_ready_i,
  input  logic        timeout_i,
  output logic        mem_req_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        alu_src_a_o,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic [1:0]  pc_source_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic        mem_err_o
);

  always_comb begin
    mem_req_o       = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = PCSRC_ALU;
    alu_src_b_o     = SRCB_B;
    alu_op_o        = ALUOP_ADD;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    // An aborted access drives nothing but the error pulse.
    mem_err_o       = timeout_i;

    if (!timeout_i) begin
      case (state_i)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          alu_op_o    = ALUOP_ADD;
          pc_source_o = PCSRC_ALU;
          // IR load and PC+4 commit only when the fetch actually completes.
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = SRCB_IMM_SH2;
          alu_op_o    = ALUOP_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          mem_req_o  = 1'b1;
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req_o    = 1'b1;
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_EXECUTE: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_B;
          alu_op_o    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_src_b_o     = SRCB_B;
          alu_op_o        = ALUOP_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
          instr_done_o    = 1'b1;
        end
        S_JUMP: begin
          pc_write_o   = 1'b1;
          pc_source_o  = PCSRC_JUMP;
          instr_done_o = 1'b1;
        end
        S_TRAP: begin
          illegal_o = 1'b1;
        end
`ifdef MC_CTRL_EXT_OPS_EN
        S_ADDI_EX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_ADD;
        end
        S_ADDI_WB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM. One instruction takes 3-5 states and
// shares a single memory port and ALU; all datapath controls are decoded
// combinationally from the current state (mem_ready where it matters).
// Adds a memory-ready handshake with optional wait timeout, an illegal-opcode
// trap state and a wrapping retired-instruction counter.
// Parameters: CNT_W (retired counter width), MEM_TIMEOUT (0 = wait forever).
// Ports:
//   clk, rst_n (async active-low), op (IR[31:26]), zero (monitor only),
//   mem_ready; mem_req/mem_read/mem_write/iord/ir_write/mem_to_reg/reg_write/
//   reg_dst/alu_src_a, pc_write/pc_write_cond/branch_ne, pc_source, alu_src_b,
//   alu_op, instr_done, retired, illegal, mem_err.
// Optional feature macro: MC_CTRL_EXT_OPS_EN (ADDI and BNE support).
module multi_cycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             mem_err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              in_mem_state;
  logic              timeout;

  logic       dec_mem_req, dec_mem_read, dec_mem_write, dec_iord, dec_ir_write;
  logic       dec_mem_to_reg, dec_reg_write, dec_reg_dst, dec_alu_src_a;
  logic       dec_pc_write, dec_pc_write_cond;
  logic [1:0] dec_pc_source, dec_alu_src_b, dec_alu_op;
  logic       dec_instr_done, dec_illegal, dec_mem_err;

  // The zero flag is consumed by the datapath through pc_write_cond.
  logic zero_unused;
  assign zero_unused = zero;

  assign in_mem_state = is_mem_state(state_q);
  assign timeout = (MEM_TIMEOUT != 0) && in_mem_state && !mem_ready &&
                   (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_EXT_OPS_EN
          OP_BNE:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      // Only LW and SW reach MEM_ADDR, so SW is the sole write case.
      S_MEM_ADDR:  state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        if (timeout || mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE:   state_d = S_R_WB;
`ifdef MC_CTRL_EXT_OPS_EN
      S_ADDI_EX:   state_d = S_ADDI_WB;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts at zero whenever a memory state is (re)entered,
  // since every exit from a stalled access passes through a zeroing path.
  always_comb begin
    wait_d = '0;
    if ((MEM_TIMEOUT != 0) && in_mem_state && !mem_ready && !timeout) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign retired_d = retired_q + CNT_W'(dec_instr_done);

  mc_ctrl_outdec u_outdec (
    .state_i         (state_q),
    .mem_ready_i     (mem_ready),
    .timeout_i       (timeout),
    .mem_req_o       (dec_mem_req),
    .mem_read_o      (dec_mem_read),
    .mem_write_o     (dec_mem_write),
    .iord_o          (dec_iord),
    .ir_write_o      (dec_ir_write),
    .mem_to_reg_o    (dec_mem_to_reg),
    .reg_write_o     (dec_reg_write),
    .reg_dst_o       (dec_reg_dst),
    .alu_src_a_o     (dec_alu_src_a),
    .pc_write_o      (dec_pc_write),
    .pc_write_cond_o (dec_pc_write_cond),
    .pc_source_o     (dec_pc_source),
    .alu_src_b_o     (dec_alu_src_b),
    .alu_op_o        (dec_alu_op),
    .instr_done_o    (dec_instr_done),
    .illegal_o       (dec_illegal),
    .mem_err_o       (dec_mem_err)
  );

  // Outputs are forced low combinationally while reset is held, so an
  // in-flight access is dropped in the same cycle reset asserts.
  assign {mem_req, mem_read, mem_write, iord, ir_write, mem_to_reg, reg_write,
          reg_dst, alu_src_a, pc_write, pc_write_cond, pc_source, alu_src_b,
          alu_op, instr_done, illegal, mem_err} =
    {20{rst_n}} &
    {dec_mem_req, dec_mem_read, dec_mem_write, dec_iord, dec_ir_write,
     dec_mem_to_reg, dec_reg_write, dec_reg_dst, dec_alu_src_a, dec_pc_write,
     dec_pc_write_cond, dec_pc_source, dec_alu_src_b, dec_alu_op,
     dec_instr_done, dec_illegal, dec_mem_err};

  assign retired = retired_q;

`ifdef MC_CTRL_EXT_OPS_EN
  // IR is stable from DECODE on, so BNE is recognised directly in BRANCH.
  assign branch_ne = rst_n & (state_q == S_BRANCH) & (op == OP_BNE);
`else
  assign branch_ne = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed testbench for multi_cycle_controller (CNT_W=4, MEM_TIMEOUT=16).
// Control outputs are packed into one 20-bit word and compared against
// hand-written per-state constants.
module tb_multi_cycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_read, mem_write, iord, ir_write, mem_to_reg;
  logic       reg_write, reg_dst, alu_src_a, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       instr_done, illegal, mem_err;
  logic [3:0] retired;

  int         n_checks;
  int         n_errors;
  logic [3:0] exp_ret;

  // {req,rd,wr,iord}_{irw,m2r,rw,rdst}_{asa,pcw,pcwc}_{pcsrc}_{srcb}_{aluop}_{done,ill,err}
  localparam logic [19:0] C_ZERO     = 20'b0000_0000_000_00_00_00_000;
  localparam logic [19:0] C_FETCH_R  = 20'b1100_1000_010_00_01_00_000;
  localparam logic [19:0] C_FETCH_W  = 20'b1100_0000_000_00_01_00_000;
  localparam logic [19:0] C_DECODE   = 20'b0000_0000_000_00_11_00_000;
  localparam logic [19:0] C_EXEC     = 20'b0000_0000_100_00_00_10_000;
  localparam logic [19:0] C_RWB      = 20'b0000_0011_000_00_00_00_100;
  localparam logic [19:0] C_MADDR    = 20'b0000_0000_100_00_10_00_000;
  localparam logic [19:0] C_MREAD    = 20'b1101_0000_000_00_00_00_000;
  localparam logic [19:0] C_MWB      = 20'b0000_0110_000_00_00_00_100;
  localparam logic [19:0] C_MWRITE_W = 20'b1011_0000_000_00_00_00_000;
  localparam logic [19:0] C_MWRITE_R = 20'b1011_0000_000_00_00_00_100;
  localparam logic [19:0] C_BRANCH   = 20'b0000_0000_101_01_00_01_100;
  localparam logic [19:0] C_JUMP     = 20'b0000_0000_010_10_00_00_100;
  localparam logic [19:0] C_TRAP     = 20'b0000_0000_000_00_00_00_010;
  localparam logic [19:0] C_TMO      = 20'b0000_0000_000_00_00_00_001;
  localparam logic [19:0] C_ADDIWB   = 20'b0000_0010_000_00_00_00_100;

  logic [19:0] ctl;
  assign ctl = {mem_req, mem_read, mem_write, iord, ir_write, mem_to_reg,
                reg_write, reg_dst, alu_src_a, pc_write, pc_write_cond,
                pc_source, alu_src_b, alu_op, instr_done, illegal, mem_err};

  multi_cycle_controller #(.CNT_W(4), .MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .retired       (retired),
    .illegal       (illegal),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (ctl !== C_ZERO) begin
      n_errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO);
    end
    mem_ready = 1'b1; #1;
    n_checks++;
    if (ctl !== C_ZERO) begin
      n_errors++; $display("FAIL reset_ctl_ready: got %b expected %b", ctl, C_ZERO);
    end
    n_checks++;
    if (retired !== 4'd0) begin
      n_errors++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b1; #1;
    n_checks++;
    if (ctl !== C_FETCH_W) begin
      n_errors++; $display("FAIL reset_fetch: got %b expected %b", ctl, C_FETCH_W);
    end
    exp_ret = 4'd0;
  endtask

  task automatic test_rtype();
    logic [19:0] exp_v [4];
    exp_v = '{C_FETCH_R, C_DECODE, C_EXEC, C_RWB};
    op = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL rtype[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1; #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait();
    logic [19:0] exp_v [8];
    logic        rdy_v [8];
    exp_v = '{C_FETCH_R, C_DECODE, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MREAD, C_MWB};
    rdy_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy_v[i]; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL lw[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1; #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_sw_timeout();
    logic [19:0] exp_v [3];
    logic        rdy_v [3];
    logic [19:0] want;
    exp_v = '{C_FETCH_R, C_DECODE, C_MADDR};
    rdy_v = '{1'b1, 1'b0, 1'b0};
    op = 6'b101011;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy_v[i]; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL sw_to_pre[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b0; #1;
      want = (i == 15) ? C_TMO : C_MWRITE_W;
      n_checks++;
      if (ctl !== want) begin
        n_errors++; $display("FAIL sw_to_wait[%0d]: got %b expected %b", i, ctl, want);
      end
      tick();
    end
    #1;
    n_checks++;
    if (ctl !== C_FETCH_W) begin
      n_errors++; $display("FAIL sw_to_fetch: got %b expected %b", ctl, C_FETCH_W);
    end
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL sw_to_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_timeout_edge();
    logic [19:0] exp_v [3];
    logic        rdy_v [3];
    exp_v = '{C_FETCH_R, C_DECODE, C_MADDR};
    rdy_v = '{1'b1, 1'b0, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy_v[i]; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL edge_pre[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    // Ready arrives on the 16th wait cycle: completion must win over abort.
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15); #1;
      n_checks++;
      if (ctl !== C_MREAD) begin
        n_errors++; $display("FAIL edge_wait[%0d]: got %b expected %b", i, ctl, C_MREAD);
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== C_MWB) begin
      n_errors++; $display("FAIL edge_wb: got %b expected %b", ctl, C_MWB);
    end
    tick();
    exp_ret = exp_ret + 4'd1; #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL edge_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_sw_normal();
    logic [19:0] exp_v [5];
    logic        rdy_v [5];
    exp_v = '{C_FETCH_R, C_DECODE, C_MADDR, C_MWRITE_W, C_MWRITE_R};
    rdy_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy_v[i]; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL sw[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1; #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL sw_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_trap();
    logic [19:0] exp_v [3];
    exp_v = '{C_FETCH_R, C_DECODE, C_TRAP};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL trap[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== C_FETCH_W) begin
      n_errors++; $display("FAIL trap_fetch: got %b expected %b", ctl, C_FETCH_W);
    end
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL trap_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_jump_wrap();
    logic [19:0] exp_v [3];
    exp_v = '{C_FETCH_R, C_DECODE, C_JUMP};
    op = 6'b000010;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== exp_v[i]) begin
          n_errors++; $display("FAIL jump%0d[%0d]: got %b expected %b", n, i, ctl, exp_v[i]);
        end
        tick();
      end
      exp_ret = exp_ret + 4'd1; #1;
      n_checks++;
      if (retired !== exp_ret) begin
        n_errors++; $display("FAIL jump%0d_retired: got %0d expected %0d", n, retired, exp_ret);
      end
    end
  endtask

  task automatic test_branch();
    logic [19:0] beq_v [3];
    beq_v = '{C_FETCH_R, C_DECODE, C_BRANCH};
    op = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== beq_v[i] || branch_ne !== 1'b0) begin
        n_errors++; $display("FAIL beq[%0d]: got %b/%b expected %b/0", i, ctl, branch_ne, beq_v[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1;
`ifdef MC_CTRL_EXT_OPS_EN
    begin
      logic [19:0] bne_v [3];
      logic [19:0] addi_v [4];
      bne_v  = '{C_FETCH_R, C_DECODE, C_BRANCH};
      addi_v = '{C_FETCH_R, C_DECODE, C_MADDR, C_ADDIWB};
      op = 6'b000101;
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== bne_v[i] || branch_ne !== (i == 2)) begin
          n_errors++; $display("FAIL bne[%0d]: got %b/%b expected %b/%0d", i, ctl, branch_ne, bne_v[i], (i == 2));
        end
        tick();
      end
      exp_ret = exp_ret + 4'd1;
      op = 6'b001000;
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== addi_v[i]) begin
          n_errors++; $display("FAIL addi[%0d]: got %b expected %b", i, ctl, addi_v[i]);
        end
        tick();
      end
      exp_ret = exp_ret + 4'd1;
    end
`else
    begin
      logic [19:0] trap_v [3];
      logic [5:0]  ops [2];
      trap_v = '{C_FETCH_R, C_DECODE, C_TRAP};
      ops    = '{6'b000101, 6'b001000};
      for (int k = 0; k < 2; k++) begin
        op = ops[k];
        for (int i = 0; i < 3; i++) begin
          mem_ready = 1'b1; #1;
          n_checks++;
          if (ctl !== trap_v[i] || branch_ne !== 1'b0) begin
            n_errors++; $display("FAIL ext_op%0d[%0d]: got %b/%b expected %b/0", k, i, ctl, branch_ne, trap_v[i]);
          end
          tick();
        end
      end
    end
`endif
    #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_errors++; $display("FAIL branch_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp_v [3];
    logic        rdy_v [3];
    exp_v = '{C_FETCH_R, C_DECODE, C_MADDR};
    rdy_v = '{1'b1, 1'b0, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy_v[i]; #1;
      n_checks++;
      if (ctl !== exp_v[i]) begin
        n_errors++; $display("FAIL rstmid_pre[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== C_MREAD) begin
      n_errors++; $display("FAIL rstmid_mread: got %b expected %b", ctl, C_MREAD);
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if (ctl !== C_ZERO) begin
      n_errors++; $display("FAIL rstmid_ctl: got %b expected %b", ctl, C_ZERO);
    end
    n_checks++;
    if (retired !== 4'd0) begin
      n_errors++; $display("FAIL rstmid_retired: got %0d expected 0", retired);
    end
    tick();
    tick();
    rst_n = 1'b1; #1;
    n_checks++;
    if (ctl !== C_FETCH_W) begin
      n_errors++; $display("FAIL rstmid_fetch: got %b expected %b", ctl, C_FETCH_W);
    end
    exp_ret = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_ret  = 4'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_timeout();
    test_timeout_edge();
    test_sw_normal();
    test_trap();
    test_jump_wrap();
    test_branch();
    test_reset_mid();
    test_rtype();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
